// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan path.
// Glyphs are active-low, bit6=g .. bit0=a.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [7:0] DIGIT_OFF = 8'hFF;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low glyph decoder.
// Non-decimal codes render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed scanner for a common-anode 7-segment bank.
// Define SEG7_LZB_EN to compile in leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 3,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic [7:0]            display,
  output logic                  frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [SW-1:0]       slot;
  logic [4*DIGITS-1:0] snap;

  logic       cnt_end;
  logic       frame_end;
  logic       blank;
  logic       hide;
  digit_t     d;
  digit_t     cur;
  logic [6:0] glyph;
  logic [6:0] seg_d;
  logic [7:0] disp_d;
`ifdef SEG7_LZB_EN
  logic       lead;
`endif

  assign cnt_end    = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end  = cnt_end && (slot == SW'(DIGITS - 1));
  assign frame_tick = frame_end;
  assign blank      = int'(cnt) < BLANK_CYCLES;

  // Pick the snapshot digit for the current slot; digit 0 is the MSD.
  always_comb begin
    d    = '0;
    cur  = '0;
    hide = 1'b0;
`ifdef SEG7_LZB_EN
    lead = 1'b1;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      d = snap[4*(DIGITS-1-i) +: 4];
`ifdef SEG7_LZB_EN
      lead = lead && (d == 4'd0);
`endif
      if (slot == SW'(i)) begin
        cur = d;
`ifdef SEG7_LZB_EN
        hide = lead && (i != DIGITS - 1);
`endif
      end
    end
  end

  bcd_to_seg7 u_dec (
    .digit (cur),
    .seg   (glyph)
  );

  always_comb begin
    seg_d  = glyph;
    disp_d = ~(8'h80 >> slot);
    if (blank || hide) begin
      seg_d  = SEG_OFF;
      disp_d = DIGIT_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      slot    <= '0;
      snap    <= '0;
      seg     <= SEG_OFF;
      display <= DIGIT_OFF;
    end else begin
      cnt <= cnt_end ? '0 : cnt + 1'b1;
      if (cnt_end)
        slot <= (slot == SW'(DIGITS - 1)) ? '0 : slot + 1'b1;
      if (frame_end)
        snap <= bcd;
      seg     <= seg_d;
      display <= disp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux with a frame-position model.
// Directed digit patterns, random input churn and async reset.
module tb_seg7_scan_mux;

  localparam int D  = 3;
  localparam int RD = 4;
  localparam int BL = 1;
  localparam int F  = D * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd = 12'h123;
  logic [6:0]  seg;
  logic [7:0]  display;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .DIGITS       (D),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bcd),
    .seg        (seg),
    .display    (display),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [6:0] seg;
    logic [7:0] disp;
    logic       tick;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  int          e;
  logic [11:0] snap;
  logic [11:0] bprev;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] g [10];
    g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v <= 9) ? g[v] : 7'h3F;
  endfunction

  // Output visible during cycle cyc reflects frame position p of the
  // previous cycle and the snapshot that was held then.
  function automatic exp_t model(input int p, input logic [11:0] s,
                                 input int cyc);
    exp_t x;
    int   sl, c, v;
    bit   show, lead;
    sl   = p / RD;
    c    = p % RD;
    v    = int'((s >> (4 * (D - 1 - sl))) & 12'hF);
    show = c >= BL;
    lead = 1'b1;
    for (int j = 0; j <= sl; j++)
      if (((s >> (4 * (D - 1 - j))) & 12'hF) != 0) lead = 1'b0;
`ifdef SEG7_LZB_EN
    if (lead && sl != D - 1) show = 1'b0;
`endif
    x.seg  = show ? glyph(v) : 7'h7F;
    x.disp = show ? (8'hFF ^ (8'h80 >> sl)) : 8'hFF;
    x.tick = (cyc % F) == F - 1;
    x.cyc  = cyc;
    return x;
  endfunction

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        check($sformatf("seg@%0d", x.cyc), 32'(seg), 32'(x.seg));
        check($sformatf("display@%0d", x.cyc), 32'(display), 32'(x.disp));
        check($sformatf("tick@%0d", x.cyc), 32'(frame_tick), 32'(x.tick));
      end
    end
  end

  task automatic run(input int n, input logic [11:0] val, input int at,
                     input bit rnd);
    int p;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      e++;
      p = (e - 1) % F;
      q.push_back(model(p, snap, e));
      if (p == F - 1) snap = bprev;
      if (k == at) bcd = val;
      if (rnd && $urandom_range(0, 5) == 0) bcd = 12'($urandom);
      bprev = bcd;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_display", 32'(display), 32'hFF);
    check("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    snap = '0;
    bprev = bcd;

    run(36, 12'h456, 17, 1'b0);
    run(24, 12'h0A5, 1, 1'b0);
    run(24, 12'h007, 1, 1'b0);
    run(24, 12'h000, 1, 1'b0);
    run(240, 12'h000, 0, 1'b1);

    r = ((F - 2) - (e % F) + F) % F;
    run(r, 12'h000, 0, 1'b0);
    @(posedge clk);
    #1;
    check("tick_pre_rst", 32'(frame_tick), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'h7F);
    check("async_display", 32'(display), 32'hFF);
    check("async_tick", 32'(frame_tick), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    snap = '0;
    bcd = 12'h908;
    bprev = bcd;
    run(60, 12'h000, 0, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
